// File: rtl/write_coprocessador.sv
// rtl/write_coprocessador.sv - custom-instruction coprocessor that writes words into a shared memory port
module write_coprocessador #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [1:0]        n,
  input  logic [31:0]       dataa,
  input  logic [31:0]       datab,
  input  logic              mem_busy,
  output logic [31:0]       result,
  output logic              done,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FINISH,
    S_DONE_PULSE
  } state_t;

  localparam logic [1:0] OP_WRITE_ADDR = 2'd0;
  localparam logic [1:0] OP_WRITE_PTR  = 2'd1;
  localparam logic [1:0] OP_SET_PTR    = 2'd2;

  state_t              state, state_nx;
  logic [1:0]          op_n, op_n_nx;
  logic [DATA_W-1:0]   op_a, op_a_nx;
  logic [ADDR_W-1:0]   op_b, op_b_nx;
  logic [ADDR_W-1:0]   ptr, ptr_nx;
  logic [ADDR_W-1:0]   saved_ptr, saved_ptr_nx;
  logic [23:0]         wr_count, wr_count_nx;
  logic [31:0]         result_nx;
  logic                done_nx;
  logic                wren_nx;
  logic [ADDR_W-1:0]   wraddress_nx;
  logic [DATA_W-1:0]   wrdata_nx;
  logic [7:0]          ptr_byte;
  logic                unused_datab;

  // Only the low ADDR_W bits of datab carry an address.
  assign unused_datab = ^datab[31:ADDR_W];
  assign ptr_byte     = 8'(ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_n      <= 2'd0;
      op_a      <= '0;
      op_b      <= '0;
      ptr       <= '0;
      saved_ptr <= '0;
      wr_count  <= 24'd0;
      result    <= 32'd0;
      done      <= 1'b0;
      wren      <= 1'b0;
      wraddress <= '0;
      wrdata    <= '0;
    end else if (clk_en) begin
      state     <= state_nx;
      op_n      <= op_n_nx;
      op_a      <= op_a_nx;
      op_b      <= op_b_nx;
      ptr       <= ptr_nx;
      saved_ptr <= saved_ptr_nx;
      wr_count  <= wr_count_nx;
      result    <= result_nx;
      done      <= done_nx;
      wren      <= wren_nx;
      wraddress <= wraddress_nx;
      wrdata    <= wrdata_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    op_n_nx      = op_n;
    op_a_nx      = op_a;
    op_b_nx      = op_b;
    ptr_nx       = ptr;
    saved_ptr_nx = saved_ptr;
    wr_count_nx  = wr_count;
    result_nx    = result;
    done_nx      = done;
    wren_nx      = wren;
    wraddress_nx = wraddress;
    wrdata_nx    = wrdata;

    case (state)
      S_IDLE: begin
        done_nx = 1'b0;
        wren_nx = 1'b0;
        if (start) begin
          op_n_nx  = n;
          op_a_nx  = dataa[DATA_W-1:0];
          op_b_nx  = datab[ADDR_W-1:0];
          state_nx = S_WRITE;
        end
      end

      S_WRITE: begin
        wren_nx = 1'b0;
        case (op_n)
          OP_WRITE_ADDR, OP_WRITE_PTR: begin
            // A busy port just retries next enabled cycle, indefinitely.
            if (!mem_busy) begin
              wraddress_nx = (op_n == OP_WRITE_PTR) ? ptr : op_b;
              wrdata_nx    = op_a;
              wren_nx      = 1'b1;
              wr_count_nx  = wr_count + 24'd1;
              if (op_n == OP_WRITE_PTR) begin
                ptr_nx = ptr + ADDR_W'(1);
              end
              state_nx = S_FINISH;
            end
          end
          OP_SET_PTR: begin
            saved_ptr_nx = ptr;
            ptr_nx       = op_b;
            state_nx     = S_FINISH;
          end
          default: begin
            state_nx = S_FINISH;
          end
        endcase
      end

      S_FINISH: begin
        wren_nx = 1'b0;
        done_nx = 1'b1;
        case (op_n)
          OP_WRITE_ADDR, OP_WRITE_PTR: result_nx = 32'(wraddress);
          OP_SET_PTR:                  result_nx = 32'(saved_ptr);
          default:                     result_nx = {wr_count, ptr_byte};
        endcase
        state_nx = S_DONE_PULSE;
      end

      default: begin
        done_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_write_coprocessador.sv
// tb/tb_write_coprocessador.sv - scoreboard bench for write_coprocessador with a behavioural model
module tb_write_coprocessador;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  n = 2'd0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] datab = 32'd0;
  logic        mem_busy = 1'b0;
  logic [31:0] result;
  logic        done;
  logic [6:0]  wraddress;
  logic [31:0] wrdata;
  logic        wren;

  write_coprocessador #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .mem_busy(mem_busy), .result(result),
    .done(done), .wraddress(wraddress), .wrdata(wrdata), .wren(wren)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_res[$];
  int m_ptr = 0;
  int m_cnt = 0;
  int wr_pulses = 0;
  int done_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain arithmetic over the documented operation rules.
  task automatic predict(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int addr;
    case (op)
      2'd0: begin
        addr = b % 128;
        exp_addr.push_back(addr); exp_data.push_back(a); exp_res.push_back(addr);
        m_cnt = (m_cnt + 1) % (1 << 24);
      end
      2'd1: begin
        addr = m_ptr;
        exp_addr.push_back(addr); exp_data.push_back(a); exp_res.push_back(addr);
        m_ptr = (m_ptr + 1) % 128;
        m_cnt = (m_cnt + 1) % (1 << 24);
      end
      2'd2: begin
        exp_res.push_back(m_ptr);
        m_ptr = b % 128;
      end
      default: exp_res.push_back(m_cnt * 256 + m_ptr);
    endcase
  endtask

  bit mon_en, mon_rst;
  always begin
    @(posedge clk);
    mon_en = clk_en;
    mon_rst = reset;
    #1;
    if (!mon_rst && mon_en) begin
      if (wren) begin
        wr_pulses++;
        if (exp_addr.size() == 0) begin
          total++;
          $display("FAIL unexpected_write actual=addr %h required=no write", wraddress);
        end else begin
          check("wr_addr", 32'(wraddress), exp_addr.pop_front());
          check("wr_data", wrdata, exp_data.pop_front());
        end
      end
      if (done) begin
        done_pulses++;
        if (exp_res.size() == 0) begin
          total++;
          $display("FAIL unexpected_done actual=result %h required=no done", result);
        end else begin
          check("result", result, exp_res.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int busy, input bit freeze);
    int k;
    predict(op, a, b);
    @(negedge clk);
    start = 1'b1; n = op; dataa = a; datab = b; mem_busy = (busy > 0);
    @(negedge clk);
    start = 1'b0; n = 2'($urandom); dataa = $urandom; datab = $urandom;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (k <= busy) check("stall_wren", 32'(wren), 32'd0);
      if (k == busy) mem_busy = 1'b0;
    end
    mem_busy = 1'b0;
    check("latency", 32'(k), (op < 2) ? 32'(busy + 2) : 32'd2);
    if (freeze) begin
      clk_en = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("freeze_done", 32'(done), 32'd1);
      end
      clk_en = 1'b1;
    end
    @(negedge clk);
    check("done_drop", 32'(done), 32'd0);
  endtask

  initial begin
    int d0, w0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_wraddress", 32'(wraddress), 32'd0);
    check("rst_wrdata", wrdata, 32'd0);
    reset = 1'b0;

    // Pointer wrap: 0x7E, 0x7F, 0x00, then STATUS = 0x301.
    issue(2'd2, 32'h1234, 32'h0000_007E, 0, 0);
    issue(2'd1, 32'hA0A0_0001, 32'h0, 0, 0);
    issue(2'd1, 32'hA0A0_0002, 32'h0, 0, 0);
    issue(2'd1, 32'hA0A0_0003, 32'h0, 0, 0);
    issue(2'd3, 32'h0, 32'h0, 0, 0);

    issue(2'd0, 32'hDEAD_BEEF, 32'h0000_0015, 0, 0);
    issue(2'd0, $urandom, $urandom, 5, 0);
    issue(2'd3, 32'h0, 32'h0, 0, 1);

    for (int i = 0; i < 30; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    // start held high: inputs change after each accept and must be ignored.
    d0 = done_pulses;
    w0 = wr_pulses;
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      predict(op, a, b);
      start = 1'b1; n = op; dataa = a; datab = b;
      @(negedge clk);
      n = 2'($urandom); dataa = $urandom; datab = $urandom;
      repeat (3) @(negedge clk);
    end
    start = 1'b0;
    check("held_done_count", 32'(done_pulses - d0), 32'd8);
    check("held_wren_count", 32'(wr_pulses - w0), 32'd8);
    issue(2'd3, 32'h0, 32'h0, 0, 0);

    // Reset while stalled in WRITE.
    @(negedge clk);
    start = 1'b1; n = 2'd0; dataa = $urandom; datab = $urandom; mem_busy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midop_wren", 32'(wren), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_busy = 1'b0;
    m_ptr = 0; m_cnt = 0; wr_pulses = 0;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_done", 32'(done), 32'd0);
      check("after_rst_wren", 32'(wren), 32'd0);
    end
    issue(2'd3, $urandom, $urandom, 0, 0);
    check("pulses_vs_count", 32'(wr_pulses), 32'(m_cnt));

    repeat (5) @(negedge clk);
    check("wr_queue_empty", 32'(exp_addr.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/write_coprocessador.md
WRITE_COPROCESSADOR -- requirements
Module: write_coprocessador

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning coprocessor memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning memory word width; dataa, datab and result stay 32 bits.
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clk_en  input  1  custom-instruction clock enable; while low, all registers hold.
REQ-006 SHALL have port start  input  1  custom-instruction start; sampled only in IDLE.
REQ-007 SHALL have port n  input  2  operation select: 0 WRITE_ADDR, 1 WRITE_PTR, 2 SET_PTR, 3 STATUS.
REQ-008 SHALL have port dataa  input  32  write data; bits [DATA_W-1:0] are used.
REQ-009 SHALL have port datab  input  32  address/pointer value; bits [ADDR_W-1:0] are used, upper bits are ignored.
REQ-010 SHALL have port mem_busy  input  1  memory write port unavailable (coprocessor owns the port).
REQ-011 SHALL have port result  output  32  instruction result, registered.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse, registered.
REQ-013 SHALL have port wraddress  output  ADDR_W  memory write address, registered.
REQ-014 SHALL have port wrdata  output  DATA_W  memory write data, registered.
REQ-015 SHALL have port wren  output  1  memory write enable, registered, high for exactly one cycle per write.

Function
REQ-016 SHALL implement four states: IDLE, WRITE, FINISH and DONE_PULSE; all transitions occur only on edges where clk_en=1.
REQ-017 IDLE: on start=1, SHALL latch n, dataa and datab, then go to WRITE; otherwise stay in IDLE with done=0 and wren=0.
REQ-018 WRITE, n=0: if mem_busy=0, SHALL set wraddress=datab[ADDR_W-1:0], wrdata=dataa and wren=1, then go to FINISH.
REQ-019 WRITE, n=1: if mem_busy=0, SHALL set wraddress=ptr, wrdata=dataa and wren=1, then ptr<=ptr+1 modulo 2^ADDR_W (ADDR_W ones wraps to 0), then go to FINISH.
REQ-020 WRITE, n=0 or n=1 with mem_busy=1: SHALL stay in WRITE with wren=0 and retry every enabled cycle; there is no timeout.
REQ-021 WRITE, n=2: SHALL capture the old ptr for result, set ptr=datab[ADDR_W-1:0] and go to FINISH; no memory write, mem_busy is ignored.
REQ-022 WRITE, n=3: SHALL go to FINISH; no memory write, mem_busy is ignored.
REQ-023 FINISH: SHALL set wren=0 and done=1, load result per REQ-024, then go to DONE_PULSE.
REQ-024 Result SHALL be loaded as follows, zero-extended to 32 bits:
- n=0 or n=1: the address written.
- n=2: the old ptr.
- n=3: {wr_count[23:0], ptr padded to 8 bits}.
REQ-025 DONE_PULSE: SHALL set done=0 and go to IDLE.
REQ-026 Minimum latency SHALL be as follows, with start sampled at edge 0 and clk_en held high:
- wren=1 after edge 1.
- done=1 after edge 2.
- done=0 after edge 3.
- next start accepted at edge 4.
REQ-027 wr_count SHALL be a 24-bit counter incremented on each wren assertion; it wraps from 0xFFFFFF to 0.
REQ-028 start outside IDLE SHALL be ignored, with no queuing.
REQ-029 When clk_en=0 in any state, state and all outputs SHALL hold, including wren or done if they are high.
REQ-030 wraddress and wrdata SHALL hold their last values while wren=0.

Reset
REQ-031 On reset=1, at the next edge, the block SHALL set: state=IDLE, done=0, wren=0, result=0, wraddress=0, wrdata=0, ptr=0, wr_count=0.
REQ-032 Reset SHALL take priority over clk_en and start.
REQ-033 Reset mid-operation SHALL abort the instruction with no done pulse; if wren was high it drops at that edge.

Verification
REQ-034 Bench SHALL cover single write: n=0, dataa=0xDEADBEEF, datab=0x15 -> wren for one cycle with wraddress=0x15 and wrdata=0xDEADBEEF, then done for one cycle with result=0x15.
REQ-035 Bench SHALL cover pointer wrap: SET_PTR datab=0x7E (result=0), then three WRITE_PTR -> wraddress 0x7E, 0x7F, 0x00; STATUS result=0x00000301.
REQ-036 Bench SHALL cover busy stall: mem_busy=1 for 5 cycles during a WRITE_ADDR -> wren stays 0 for those 5 cycles, then pulses once; done follows one cycle later.
REQ-037 Bench SHALL cover clk_en freeze: clk_en=0 for 3 cycles while done=1 -> done stays high for 3 more cycles; a single DONE_PULSE follows when clk_en returns.
REQ-038 Bench SHALL cover reset mid-op: reset asserted in WRITE with mem_busy=1 -> no wren, no done; STATUS afterward returns 0.
REQ-039 Bench SHALL cover ignored start: start held high continuously -> one instruction completes every 4 enabled cycles, and wr_count equals the number of wren pulses.
